// File: rtl/lsu_pkg.sv
// Shared definitions for the LSU bus master: access size codes,
// FSM state encoding and the default idle bus address.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    localparam logic [31:0] IDLE_ADDR_DEF = 32'h0000_0000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_STORE,
        ST_RMW_RD,
        ST_RMW_WR,
        ST_RESP
    } state_t;

endpackage

// File: rtl/lsu_byte_lane.sv
// Combinational lane logic: extracts and sign/zero-extends load data,
// and merges a byte/half store into a word.
// Ports: size, addr_lo, is_unsigned, rword, wdata -> ldata, mword.
module lsu_byte_lane
    import lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic        is_unsigned,
    input  logic [31:0] rword,
    input  logic [31:0] wdata,
    output logic [31:0] ldata,
    output logic [31:0] mword
);

    logic [7:0]  b;
    logic [15:0] h;
    logic        sb;
    logic        sh;

    always_comb begin
        b = 8'h00;
        case (addr_lo)
            2'd0:    b = rword[7:0];
            2'd1:    b = rword[15:8];
            2'd2:    b = rword[23:16];
            default: b = rword[31:24];
        endcase
        h  = addr_lo[1] ? rword[31:16] : rword[15:0];
        sb = ~is_unsigned & b[7];
        sh = ~is_unsigned & h[15];
    end

    always_comb begin
        ldata = rword;
        mword = wdata;
        case (size)
            SZ_BYTE: begin
                ldata = {{24{sb}}, b};
                mword = rword;
                mword[{addr_lo, 3'b000} +: 8] = wdata[7:0];
            end
            SZ_HALF: begin
                ldata = {{16{sh}}, h};
                mword = rword;
                mword[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
            end
            default: begin
                ldata = rword;
                mword = wdata;
            end
        endcase
    end

endmodule

// File: rtl/lsu_bus_master.sv
// LSU bus master: one request at a time onto a word-wide memory port,
// with read-modify-write for sub-word stores.
// Ports: clk, reset, req_* handshake, resp_* handshake, mem_* port.
// Option: define LSU_MISALIGN_TRAP_EN to trap misaligned half/word.
module lsu_bus_master
    import lsu_pkg::*;
#(
    parameter logic [31:0] IDLE_ADDR = IDLE_ADDR_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    state_t      state_q;
    state_t      state_d;
    logic [31:0] addr_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [31:0] wdata_q;
    logic [31:0] rword_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic        req_bad;
    logic        accept;
    logic [31:0] lane_word;
    logic [31:0] ldata;
    logic [31:0] mword;

    assign accept = req_valid && (state_q == ST_IDLE);

    always_comb begin
        req_bad = (req_size == SZ_ILL);
`ifdef LSU_MISALIGN_TRAP_EN
        if (req_size == SZ_HALF && req_addr[0])
            req_bad = 1'b1;
        if (req_size == SZ_WORD && req_addr[1:0] != 2'b00)
            req_bad = 1'b1;
`endif
    end

    // Loads extract straight from the bus; merges use the captured word.
    assign lane_word = (state_q == ST_LOAD) ? mem_rdata : rword_q;

    lsu_byte_lane u_lane (
        .size        (size_q),
        .addr_lo     (addr_q[1:0]),
        .is_unsigned (uns_q),
        .rword       (lane_word),
        .wdata       (wdata_q),
        .ldata       (ldata),
        .mword       (mword)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            wdata_q <= '0;
            rword_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q  <= req_addr;
                size_q  <= req_size;
                uns_q   <= req_unsigned;
                wdata_q <= req_wdata;
                rdata_q <= '0;
                err_q   <= req_bad;
            end
            if (state_q == ST_LOAD)
                rdata_q <= ldata;
            if (state_q == ST_RMW_RD)
                rword_q <= mem_rdata;
        end
    end

    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = IDLE_ADDR;
        mem_wdata  = '0;
        unique case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_bad)
                        state_d = ST_RESP;
                    else if (!req_we)
                        state_d = ST_LOAD;
                    else if (req_size == SZ_WORD)
                        state_d = ST_STORE;
                    else
                        state_d = ST_RMW_RD;
                end
            end
            ST_LOAD: begin
                mem_addr = {addr_q[31:2], 2'b00};
                state_d  = ST_RESP;
            end
            ST_STORE: begin
                mem_addr  = {addr_q[31:2], 2'b00};
                mem_we    = 1'b1;
                mem_wdata = wdata_q;
                state_d   = ST_RESP;
            end
            ST_RMW_RD: begin
                mem_addr = {addr_q[31:2], 2'b00};
                state_d  = ST_RMW_WR;
            end
            ST_RMW_WR: begin
                mem_addr  = {addr_q[31:2], 2'b00};
                mem_we    = 1'b1;
                mem_wdata = mword;
                state_d   = ST_RESP;
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_lsu_bus_master.sv
// Directed self-checking bench for lsu_bus_master with a
// small word memory model on the mem_* port.
module tb_lsu_bus_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:3];
    logic        pre;
    int          wr_cnt;
    logic [31:0] last_wa;
    logic [31:0] last_wd;

    int n_checks;
    int n_fail;

    always #5 clk = ~clk;

    lsu_bus_master dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    assign mem_rdata = mem[mem_addr[3:2]];

    always @(posedge clk) begin
        if (pre) begin
            mem[0] <= 32'h1234_5678;
            mem[1] <= 32'h8899_AABB;
            mem[2] <= 32'h0;
            mem[3] <= 32'h0;
            wr_cnt <= 0;
        end else if (mem_we) begin
            mem[mem_addr[3:2]] <= mem_wdata;
            wr_cnt  <= wr_cnt + 1;
            last_wa <= mem_addr;
            last_wd <= mem_wdata;
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    logic [31:0] r_data;
    logic        r_err;
    logic [31:0] r_lat;
    int          w0;

    task automatic issue(input logic we, input logic [1:0] size,
                         input logic uns, input logic [31:0] addr,
                         input logic [31:0] wdata);
        @(negedge clk);
        check("req_ready_idle", {31'b0, req_ready}, 32'd1);
        w0           = wr_cnt;
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_resp();
        r_lat = 32'd99;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (resp_valid) begin
                r_lat = 32'(i);
                break;
            end
        end
        r_data = resp_rdata;
        r_err  = resp_err;
    endtask

    task automatic finish_resp();
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        check("req_ready_after", {31'b0, req_ready}, 32'd1);
    endtask

    task automatic txn(input string tag, input logic we,
                       input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] e_data, input logic e_err,
                       input logic [31:0] e_lat, input int e_wr);
        issue(we, size, uns, addr, wdata);
        wait_resp();
        check({tag, "_lat"}, r_lat, e_lat);
        check({tag, "_data"}, r_data, e_data);
        check({tag, "_err"}, {31'b0, r_err}, {31'b0, e_err});
        finish_resp();
        check({tag, "_writes"}, 32'(wr_cnt - w0), 32'(e_wr));
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        reset        = 1'b1;
        pre          = 1'b1;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        resp_ready   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_mem_we", {31'b0, mem_we}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        check("rst_resp_err", {31'b0, resp_err}, 32'd0);
        reset = 1'b0;
        pre   = 1'b0;

        txn("lb_8005", 1'b0, 2'b00, 1'b0, 32'h8005, 32'h0,
            32'hFFFF_FFAA, 1'b0, 32'd2, 0);
        txn("lhu_8006", 1'b0, 2'b01, 1'b1, 32'h8006, 32'h0,
            32'h0000_8899, 1'b0, 32'd2, 0);

        txn("sb_8006", 1'b1, 2'b00, 1'b0, 32'h8006, 32'h55,
            32'h0, 1'b0, 32'd3, 1);
        check("sb_waddr", last_wa, 32'h8004);
        check("sb_wdata", last_wd, 32'h8855_AABB);

        txn("sw_8000", 1'b1, 2'b10, 1'b0, 32'h8000, 32'hDEAD_BEEF,
            32'h0, 1'b0, 32'd2, 1);
        check("sw_waddr", last_wa, 32'h8000);
        check("sw_wdata", last_wd, 32'hDEAD_BEEF);

        txn("size11", 1'b0, 2'b11, 1'b0, 32'h8004, 32'h0,
            32'h0, 1'b1, 32'd1, 0);

`ifdef LSU_MISALIGN_TRAP_EN
        txn("lw_8002", 1'b0, 2'b10, 1'b0, 32'h8002, 32'h0,
            32'h0, 1'b1, 32'd1, 0);
        txn("sw_mis", 1'b1, 2'b10, 1'b0, 32'h8005, 32'h1111_1111,
            32'h0, 1'b1, 32'd1, 0);
`else
        txn("lw_8002", 1'b0, 2'b10, 1'b0, 32'h8002, 32'h0,
            32'hDEAD_BEEF, 1'b0, 32'd2, 0);
`endif

        issue(1'b0, 2'b01, 1'b0, 32'h8004, 32'h0);
        wait_resp();
        check("lh_hold_lat", r_lat, 32'd2);
        check("lh_hold_data", r_data, 32'hFFFF_AABB);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("hold_valid", {31'b0, resp_valid}, 32'd1);
            check("hold_rdata", resp_rdata, 32'hFFFF_AABB);
            check("hold_req_ready", {31'b0, req_ready}, 32'd0);
        end
        finish_resp();

        txn("sh_8006", 1'b1, 2'b01, 1'b0, 32'h8006, 32'hAB_1234,
            32'h0, 1'b0, 32'd3, 1);
        check("sh_wdata", last_wd, 32'h1234_AABB);

        issue(1'b1, 2'b00, 1'b0, 32'h8004, 32'h77);
        reset = 1'b1;
        #1;
        check("rmw_rst_we", {31'b0, mem_we}, 32'd0);
        repeat (2) begin
            @(negedge clk);
            check("rmw_rst_we_hold", {31'b0, mem_we}, 32'd0);
        end
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rmw_rst_ready", {31'b0, req_ready}, 32'd1);
        check("rmw_rst_noresp", {31'b0, resp_valid}, 32'd0);
        check("rmw_rst_mem", mem[1], 32'h1234_AABB);
        check("rmw_rst_writes", 32'(wr_cnt - w0), 32'd0);

        txn("lbu_post", 1'b0, 2'b00, 1'b1, 32'h8007, 32'h0,
            32'h0000_0012, 1'b0, 32'd2, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
